udp_port_filter: RTL and testbench

Port-based admission filter on the UDP receive path, placed directly upstream of the port switch, between the UDP stack's RX header/payload outputs and the switch's RX sink. Frames whose destination port matches an entry of the configured port table are forwarded unchanged. All other frames are consumed and discarded in full, so the switch only ever sees traffic for ports it serves. An optional saturating counter reports the number of dropped frames.

---
 rtl/udp_port_filter.sv | 236 +++++++++++++++++++++++
 tb/tb_udp_port_filter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_port_filter.sv
//-----------------------------------------------------------------------------
// udp_port_filter
//
// Port-based admission filter on the UDP receive path. Sits between the UDP
// stack's RX header/payload outputs and the port switch's RX sink. A frame
// whose destination port appears in the PORTS table is forwarded unchanged.
// Every other frame is consumed and discarded in full, so the switch only
// ever sees traffic for ports it serves.
//
// Only one frame is in flight at a time. A new header is accepted only when
// both the previous frame's last payload beat and its header have completed.
//
// Build option:
//   UDP_PORT_FILTER_STATS_EN  defined   -> drop_count is a 32-bit saturating
//                                          count of dropped frames.
//                             undefined -> drop_count is tied to zero. The
//                                          port is kept so both builds share
//                                          one interface.
//
// Parameters:
//   PORT_COUNT   number of accepted destination ports (>= 1)
//   PORTS        accepted destination port table; every instance sets it
//                explicitly.
//   DATA_WIDTH   payload tdata width in bits
//   KEEP_WIDTH   payload tkeep width in bits
//
// Ports:
//   clk                     single clock for all logic
//   reset                   synchronous, active-high reset
//   sink_hdr_*              UDP RX header from the stack (valid/ready + fields)
//   sink_t*                 AXI-Stream payload from the stack
//   source_hdr_*            registered, filtered header toward the switch
//   source_t*               filtered payload toward the switch (combinational
//                           pass-through while forwarding)
//   drop_count              dropped-frame count (see build option above)
//-----------------------------------------------------------------------------
module udp_port_filter #(
   parameter int          PORT_COUNT = 2,
   parameter bit [15:0]   PORTS [PORT_COUNT] = '{default: 16'd0},
   parameter int          DATA_WIDTH = 64,
   parameter int          KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset,

   // Header sink (from the UDP stack)
   input  logic                  sink_hdr_valid,
   output logic                  sink_hdr_ready,
   input  logic [31:0]           sink_hdr_source_ip,
   input  logic [31:0]           sink_hdr_dest_ip,
   input  logic [15:0]           sink_hdr_source_port,
   input  logic [15:0]           sink_hdr_dest_port,
   input  logic [15:0]           sink_hdr_length,
   input  logic [15:0]           sink_hdr_checksum,

   // Payload sink (from the UDP stack)
   input  logic                  sink_tvalid,
   output logic                  sink_tready,
   input  logic [DATA_WIDTH-1:0] sink_tdata,
   input  logic [KEEP_WIDTH-1:0] sink_tkeep,
   input  logic                  sink_tlast,
   input  logic                  sink_tuser,

   // Header source (toward the switch)
   output logic                  source_hdr_valid,
   input  logic                  source_hdr_ready,
   output logic [31:0]           source_hdr_source_ip,
   output logic [31:0]           source_hdr_dest_ip,
   output logic [15:0]           source_hdr_source_port,
   output logic [15:0]           source_hdr_dest_port,
   output logic [15:0]           source_hdr_length,
   output logic [15:0]           source_hdr_checksum,

   // Payload source (toward the switch)
   output logic                  source_tvalid,
   input  logic                  source_tready,
   output logic [DATA_WIDTH-1:0] source_tdata,
   output logic [KEEP_WIDTH-1:0] source_tkeep,
   output logic                  source_tlast,
   output logic                  source_tuser,

   // Statistics
   output logic [31:0]           drop_count
);

   //--------------------------------------------------------------------------
   // FSM encoding
   //--------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE     = 2'd0;  // waiting for a header
   localparam logic [1:0] ST_FWD      = 2'd1;  // forwarding payload
   localparam logic [1:0] ST_FWD_TAIL = 2'd2;  // payload done, header pending
   localparam logic [1:0] ST_DROP     = 2'd3;  // discarding payload

   logic [1:0] state;
   logic [1:0] state_next;

   //--------------------------------------------------------------------------
   // Handshake qualifiers
   //--------------------------------------------------------------------------
   logic port_match;
   logic hdr_accept;
   logic source_hdr_fire;
   logic beat_last;

   // The header is only ever accepted in IDLE, and that depends solely on
   // the registered state, so there is no combinational path from
   // sink_hdr_valid back to sink_hdr_ready.
   assign sink_hdr_ready  = (state == ST_IDLE);
   assign hdr_accept      = sink_hdr_valid && sink_hdr_ready;
   assign source_hdr_fire = source_hdr_valid && source_hdr_ready;
   assign beat_last       = sink_tvalid && sink_tready && sink_tlast;

   // Destination port lookup: OR of equality against every table entry.
   // NOTE: every signal assigned in an always_comb gets a default value first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      port_match = 1'b0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         if (sink_hdr_dest_port == PORTS[i]) begin
            port_match = 1'b1;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Payload path
   //--------------------------------------------------------------------------
   // Data lanes are wired straight through; only the valid/ready pair is
   // gated by the state, so the switch sees a beat only while forwarding.
   assign source_tdata  = sink_tdata;
   assign source_tkeep  = sink_tkeep;
   assign source_tlast  = sink_tlast;
   assign source_tuser  = sink_tuser;
   assign source_tvalid = (state == ST_FWD) && sink_tvalid;

   always_comb begin
      sink_tready = 1'b0;
      case (state)
         ST_FWD:  sink_tready = source_tready;
         ST_DROP: sink_tready = 1'b1;   // swallow the whole frame
         default: sink_tready = 1'b0;   // IDLE and FWD_TAIL take no payload
      endcase
   end

   //--------------------------------------------------------------------------
   // Next-state logic
   //--------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (hdr_accept) begin
               state_next = port_match ? ST_FWD : ST_DROP;
            end
         end
         ST_FWD: begin
            // The frame is finished only when both the last beat and the
            // header have gone downstream; a header still waiting (and not
            // taken this very cycle) parks us in FWD_TAIL.
            if (beat_last) begin
               if (!source_hdr_valid || source_hdr_fire) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_FWD_TAIL;
               end
            end
         end
         ST_FWD_TAIL: begin
            if (source_hdr_fire) begin
               state_next = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (beat_last) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   //--------------------------------------------------------------------------
   // State and header output registers
   //--------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= ST_IDLE;
         source_hdr_valid       <= 1'b0;
         source_hdr_source_ip   <= '0;
         source_hdr_dest_ip     <= '0;
         source_hdr_source_port <= '0;
         source_hdr_dest_port   <= '0;
         source_hdr_length      <= '0;
         source_hdr_checksum    <= '0;
      end else begin
         state <= state_next;

         // Accept happens only in IDLE, where no header is pending, so the
         // set and clear below can never collide.
         if (hdr_accept && port_match) begin
            source_hdr_valid       <= 1'b1;
            source_hdr_source_ip   <= sink_hdr_source_ip;
            source_hdr_dest_ip     <= sink_hdr_dest_ip;
            source_hdr_source_port <= sink_hdr_source_port;
            source_hdr_dest_port   <= sink_hdr_dest_port;
            source_hdr_length      <= sink_hdr_length;
            source_hdr_checksum    <= sink_hdr_checksum;
         end else if (source_hdr_fire) begin
            source_hdr_valid <= 1'b0;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Dropped-frame counter
   //--------------------------------------------------------------------------
`ifdef UDP_PORT_FILTER_STATS_EN
   logic drop_fire;

   assign drop_fire = hdr_accept && !port_match;

   // Counts at the non-matching header handshake and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (drop_fire && (drop_count != 32'hFFFF_FFFF)) begin
         drop_count <= drop_count + 32'd1;
      end
   end
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_udp_port_filter.sv
//-----------------------------------------------------------------------------
// tb_udp_port_filter
//
// Scoreboard bench for udp_port_filter. Drivers push the expected header and
// payload beats of every frame that should be forwarded into queues; monitors
// pop and compare whenever the DUT completes a source handshake. Directed
// checks cover reset values, drop behaviour, header stall, back-pressure,
// mid-frame reset and counter saturation.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_udp_port_filter;

   localparam int DW = 64;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [31:0] source_ip;
      logic [31:0] dest_ip;
      logic [15:0] source_port;
      logic [15:0] dest_port;
      logic [15:0] length;
      logic [15:0] checksum;
   } hdr_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk;
   logic          reset;
   logic          sink_hdr_valid;
   logic          sink_hdr_ready;
   hdr_t          sink_hdr;
   logic          sink_tvalid;
   logic          sink_tready;
   logic [DW-1:0] sink_tdata;
   logic [KW-1:0] sink_tkeep;
   logic          sink_tlast;
   logic          sink_tuser;
   logic          source_hdr_valid;
   logic          source_hdr_ready;
   logic [31:0]   source_hdr_source_ip;
   logic [31:0]   source_hdr_dest_ip;
   logic [15:0]   source_hdr_source_port;
   logic [15:0]   source_hdr_dest_port;
   logic [15:0]   source_hdr_length;
   logic [15:0]   source_hdr_checksum;
   logic          source_tvalid;
   logic          source_tready;
   logic [DW-1:0] source_tdata;
   logic [KW-1:0] source_tkeep;
   logic          source_tlast;
   logic          source_tuser;
   logic [31:0]   drop_count;

   udp_port_filter #(
      .PORT_COUNT (2),
      .PORTS      ('{16'd1234, 16'd5678}),
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .sink_hdr_valid         (sink_hdr_valid),
      .sink_hdr_ready         (sink_hdr_ready),
      .sink_hdr_source_ip     (sink_hdr.source_ip),
      .sink_hdr_dest_ip       (sink_hdr.dest_ip),
      .sink_hdr_source_port   (sink_hdr.source_port),
      .sink_hdr_dest_port     (sink_hdr.dest_port),
      .sink_hdr_length        (sink_hdr.length),
      .sink_hdr_checksum      (sink_hdr.checksum),
      .sink_tvalid            (sink_tvalid),
      .sink_tready            (sink_tready),
      .sink_tdata             (sink_tdata),
      .sink_tkeep             (sink_tkeep),
      .sink_tlast             (sink_tlast),
      .sink_tuser             (sink_tuser),
      .source_hdr_valid       (source_hdr_valid),
      .source_hdr_ready       (source_hdr_ready),
      .source_hdr_source_ip   (source_hdr_source_ip),
      .source_hdr_dest_ip     (source_hdr_dest_ip),
      .source_hdr_source_port (source_hdr_source_port),
      .source_hdr_dest_port   (source_hdr_dest_port),
      .source_hdr_length      (source_hdr_length),
      .source_hdr_checksum    (source_hdr_checksum),
      .source_tvalid          (source_tvalid),
      .source_tready          (source_tready),
      .source_tdata           (source_tdata),
      .source_tkeep           (source_tkeep),
      .source_tlast           (source_tlast),
      .source_tuser           (source_tuser),
      .drop_count             (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // Scoreboard state
   //--------------------------------------------------------------------------
   hdr_t        hdr_exp_q[$];
   beat_t       beat_exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_drops = 32'd0;
   bit          bp_toggle = 1'b0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag_unexpected(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output handshake with nothing expected (t=%0t)", name, $time);
   endtask

   //--------------------------------------------------------------------------
   // Monitors: sample on the falling edge, away from the active edge
   //--------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!reset && source_hdr_valid && source_hdr_ready) begin
         if (hdr_exp_q.size() == 0) begin
            flag_unexpected("src_hdr");
         end else begin
            check("src_hdr_fields",
                  {source_hdr_source_ip, source_hdr_dest_ip, source_hdr_source_port,
                   source_hdr_dest_port, source_hdr_length, source_hdr_checksum},
                  hdr_exp_q.pop_front());
         end
      end
      if (!reset && source_tvalid && source_tready) begin
         if (beat_exp_q.size() == 0) begin
            flag_unexpected("src_beat");
         end else begin
            check("src_beat", {source_tdata, source_tkeep, source_tlast, source_tuser},
                  beat_exp_q.pop_front());
         end
      end
   end

   // Downstream payload back-pressure generator
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_toggle) source_tready = ~source_tready;
      end
   end

   //--------------------------------------------------------------------------
   // Drivers
   //--------------------------------------------------------------------------
   function automatic hdr_t mk_hdr(input logic [15:0] port, input logic [7:0] tag);
      hdr_t h;
      h.source_ip   = {24'hC0A801, tag};
      h.dest_ip     = {24'h0A0000, ~tag};
      h.source_port = {8'h40, tag};
      h.dest_port   = port;
      h.length      = {8'h00, tag} + 16'd8;
      h.checksum    = {tag, 8'h5A};
      return h;
   endfunction

   // Presents a header and waits for the sink handshake. Called right after
   // a rising edge (+1); returns one unit after the accepting edge.
   task automatic send_hdr(input hdr_t h, input bit fwd);
      int waits;
      waits = 0;
      sink_hdr       = h;
      sink_hdr_valid = 1'b1;
      if (fwd) begin
         hdr_exp_q.push_back(h);
      end else begin
`ifdef UDP_PORT_FILTER_STATS_EN
         if (exp_drops != 32'hFFFF_FFFF) exp_drops = exp_drops + 32'd1;
`endif
      end
      @(negedge clk);
      while (!sink_hdr_ready && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      check("hdr_accept_in_budget", 128'(waits < 40), 128'(1));
      @(posedge clk);
      #1;
      sink_hdr_valid = 1'b0;
      if (fwd) check("hdr_valid_next_cycle", 128'(source_hdr_valid), 128'(1));
      check("drop_count", 128'(drop_count), 128'(exp_drops));
   endtask

   // Drives beats [0, stop) of an n-beat frame tagged 'base'.
   task automatic send_beats(input int n, input int stop, input logic [31:0] base,
                             input bit fwd);
      beat_t b;
      int    waits;
      for (int i = 0; i < stop; i++) begin
         b.data = {base, 32'(i)};
         b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
         b.last = (i == n - 1);
         b.user = (i == n - 1) && base[0];
         sink_tdata  = b.data;
         sink_tkeep  = b.keep;
         sink_tlast  = b.last;
         sink_tuser  = b.user;
         sink_tvalid = 1'b1;
         if (fwd) beat_exp_q.push_back(b);
         waits = 0;
         @(negedge clk);
         while (!sink_tready && waits < 40) begin
            @(negedge clk);
            waits++;
         end
         if (fwd) check("beat_in_budget", 128'(waits < 40), 128'(1));
         else     check("drop_tready_waits", 128'(waits), 128'(0));
         @(posedge clk);
         #1;
      end
      sink_tvalid = 1'b0;
      sink_tlast  = 1'b0;
   endtask

   task automatic settle_and_check_empty(input string name);
      repeat (3) @(posedge clk);
      #1;
      check({name, "_hdr_q_empty"},  128'(hdr_exp_q.size()),  128'(0));
      check({name, "_beat_q_empty"}, 128'(beat_exp_q.size()), 128'(0));
   endtask

   //--------------------------------------------------------------------------
   // Stimulus
   //--------------------------------------------------------------------------
   initial begin
      reset            = 1'b1;
      sink_hdr_valid   = 1'b0;
      sink_hdr         = '0;
      sink_tvalid      = 1'b1;   // must stay blocked during reset
      sink_tdata       = '0;
      sink_tkeep       = '0;
      sink_tlast       = 1'b0;
      sink_tuser       = 1'b0;
      source_hdr_ready = 1'b1;
      source_tready    = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_hdr_valid", 128'(source_hdr_valid), 128'(0));
      check("rst_tvalid",    128'(source_tvalid),    128'(0));
      check("rst_sink_tready", 128'(sink_tready),    128'(0));
      check("rst_drop_count", 128'(drop_count),      128'(0));
      check("rst_hdr_regs",
            {source_hdr_source_ip, source_hdr_dest_ip, source_hdr_source_port,
             source_hdr_dest_port, source_hdr_length, source_hdr_checksum}, 128'(0));
      check("rst_sink_hdr_ready", 128'(sink_hdr_ready), 128'(1));
      sink_tvalid = 1'b0;
      reset       = 1'b0;
      @(posedge clk);
      #1;

      // Matched frame, 4 beats
      send_hdr(mk_hdr(16'd5678, 8'h11), 1'b1);
      send_beats(4, 4, 32'hA001, 1'b1);
      settle_and_check_empty("matched");
      check("matched_drop_count", 128'(drop_count), 128'(0));

      // Unmatched frame, 3 beats, then a frame to 1234
      send_hdr(mk_hdr(16'd80, 8'h22), 1'b0);
      send_beats(3, 3, 32'hB000, 1'b0);
      settle_and_check_empty("unmatched");
      check("unmatched_drop_count", 128'(drop_count), 128'(exp_drops));
      send_hdr(mk_hdr(16'd1234, 8'h33), 1'b1);
      send_beats(2, 2, 32'hC001, 1'b1);
      settle_and_check_empty("after_drop");

      // Header stalled downstream while a single-beat frame completes
      source_hdr_ready = 1'b0;
      send_hdr(mk_hdr(16'd1234, 8'h44), 1'b1);
      send_beats(1, 1, 32'hD000, 1'b1);
      check("tail_sink_hdr_ready", 128'(sink_hdr_ready), 128'(0));
      check("tail_src_hdr_valid",  128'(source_hdr_valid), 128'(1));
      check("tail_sink_tready",    128'(sink_tready), 128'(0));
      @(posedge clk);
      #1;
      check("tail_sink_hdr_ready_hold", 128'(sink_hdr_ready), 128'(0));
      source_hdr_ready = 1'b1;
      @(posedge clk);
      #1;
      check("tail_done_sink_hdr_ready", 128'(sink_hdr_ready), 128'(1));
      check("tail_done_src_hdr_valid",  128'(source_hdr_valid), 128'(0));
      settle_and_check_empty("stall");

      // Back-pressure toggling every cycle over an 8-beat frame
      bp_toggle = 1'b1;
      send_hdr(mk_hdr(16'd5678, 8'h55), 1'b1);
      send_beats(8, 8, 32'hE001, 1'b1);
      bp_toggle = 1'b0;
      source_tready = 1'b1;
      settle_and_check_empty("backpressure");

      // Reset after beat 2 of a 6-beat matched frame
      send_hdr(mk_hdr(16'd5678, 8'h66), 1'b1);
      send_beats(6, 2, 32'hF000, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_drops   = 32'd0;
      sink_tvalid = 1'b1;
      #1;
      check("midrst_hdr_valid",  128'(source_hdr_valid), 128'(0));
      check("midrst_tvalid",     128'(source_tvalid),    128'(0));
      check("midrst_drop_count", 128'(drop_count),       128'(0));
      sink_tvalid = 1'b0;
      reset       = 1'b0;
      @(posedge clk);
      #1;
      send_hdr(mk_hdr(16'd1234, 8'h77), 1'b1);
      send_beats(1, 1, 32'h7001, 1'b1);
      settle_and_check_empty("after_reset");

      // Counter saturation
`ifdef UDP_PORT_FILTER_STATS_EN
      force dut.drop_count = 32'hFFFF_FFFE;
      #1;
      release dut.drop_count;
      exp_drops = 32'hFFFF_FFFE;
      @(posedge clk);
      #1;
`endif
      for (int f = 0; f < 3; f++) begin
         send_hdr(mk_hdr(16'd9999, 8'(8'h80 + f)), 1'b0);
         send_beats(1, 1, 32'h9000, 1'b0);
         check("sat_drop_count", 128'(drop_count), 128'(exp_drops));
      end
      settle_and_check_empty("saturation");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
